// File: rtl/arb_pkg.sv
// Shared types for the round-robin select sequencer.
// Requester count, select width and FSM state encoding.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_any
);

  logic [SEL_W-1:0] w_idx;

  // Scan from farthest to nearest so the slot closest to ptr wins
  always_comb begin
    o_winner = i_ptr;
    w_idx    = i_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + SEL_W'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rr_select_sequencer.sv
// Round-robin grant sequencer driving a 2-to-4 decoder.
// One idle cycle is forced between grants so outputs never overlap.
module rr_select_sequencer
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               timeout,
  output logic               busy
);

  localparam int CW =
    (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] LIM =
    CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CW-1:0] CMAX = '1;

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [CW-1:0]    r_cnt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_hit;
  logic             w_rel;
  logic             w_to;

  rr_pick u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Release priority: done, then request drop, then hold limit
  assign w_hit = (HOLD_MAX != 0) && (r_cnt == LIM);
  assign w_rel = done || !req[sel] || w_hit;
  assign w_to  = !done && req[sel] && w_hit;

  // Grant FSM with registered select, enable, timeout and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      sel     <= '0;
      sel_en  <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            sel     <= w_winner;
            sel_en  <= 1'b1;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_rel) begin
            sel_en  <= 1'b0;
            r_ptr   <= sel + 1'b1;
            timeout <= w_to;
            r_state <= ST_RELEASE;
          end else if (r_cnt != CMAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          sel_en  <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
